// File: rtl/cfu_cmd_issuer.sv
// Autonomous CFU initiator: queues host commands, issues them one at a time on the
// CFU cmd channel, collects kept responses into a FIFO and watches for hung transactions.
module cfu_cmd_issuer #(
  parameter int QDEPTH  = 4,
  parameter int RDEPTH  = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             q_valid,
  output logic             q_ready,
  input  logic [9:0]       q_function_id,
  input  logic [31:0]      q_inputs_0,
  input  logic [31:0]      q_inputs_1,
  input  logic             q_keep,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [31:0]      r_data,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [9:0]       cmd_payload_function_id,
  output logic [31:0]      cmd_payload_inputs_0,
  output logic [31:0]      cmd_payload_inputs_1,
  input  logic             rsp_valid,
  output logic             rsp_ready,
  input  logic [31:0]      rsp_payload_outputs_0,
  output logic             busy,
  output logic             timeout_err,
  input  logic             err_clear,
  output logic [CNT_W-1:0] issued_count
);

  localparam int QAW = $clog2(QDEPTH);
  localparam int RAW = $clog2(RDEPTH);
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [74:0]       cmem_q [QDEPTH];
  logic [QAW-1:0]    cwr_q, cwr_d, crd_q, crd_d;
  logic [QAW:0]      ccnt_q, ccnt_d;
  logic [31:0]       rmem_q [RDEPTH];
  logic [RAW-1:0]    rwr_q, rwr_d, rrd_q, rrd_d;
  logic [RAW:0]      rcnt_q, rcnt_d;
  logic [WDW-1:0]    wdog_q, wdog_d;
  logic              err_q, err_d;
  logic              keep_q;
  logic [9:0]        fid_q;
  logic [31:0]       in0_q, in1_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              issue, cmdDone, rspDone;
  logic              cpush, rpush, rpop;
  logic [74:0]       head;

  assign head      = cmem_q[crd_q];
  assign q_ready   = ccnt_q != (QAW+1)'(QDEPTH);
  assign r_valid   = rcnt_q != '0;
  assign r_data    = rmem_q[rrd_q];
  assign cmd_valid = state_q == S_CMD;
  assign rsp_ready = state_q == S_WAIT;
  assign busy      = (state_q != S_IDLE) || (ccnt_q != '0);
  assign timeout_err = err_q;
  assign issued_count = cnt_q;
  assign cmd_payload_function_id = fid_q;
  assign cmd_payload_inputs_0    = in0_q;
  assign cmd_payload_inputs_1    = in1_q;

  assign cpush = q_valid && q_ready;
  assign rpush = rspDone && keep_q;
  assign rpop  = r_ready && r_valid;

  // A kept command only issues once its response slot is guaranteed, so rsp_ready never stalls.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    cmdDone = 1'b0;
    rspDone = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ccnt_q != '0 && (!head[74] || rcnt_q < (RAW+1)'(RDEPTH))) begin
          issue   = 1'b1;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (cmd_ready) begin
          cmdDone = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_valid) begin
          rspDone = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cwr_d  = cpush ? cwr_q + QAW'(1) : cwr_q;
    crd_d  = issue ? crd_q + QAW'(1) : crd_q;
    ccnt_d = ccnt_q;
    if (cpush && !issue) ccnt_d = ccnt_q + (QAW+1)'(1);
    else if (!cpush && issue) ccnt_d = ccnt_q - (QAW+1)'(1);
    rwr_d  = rpush ? rwr_q + RAW'(1) : rwr_q;
    rrd_d  = rpop ? rrd_q + RAW'(1) : rrd_q;
    rcnt_d = rcnt_q;
    if (rpush && !rpop) rcnt_d = rcnt_q + (RAW+1)'(1);
    else if (!rpush && rpop) rcnt_d = rcnt_q - (RAW+1)'(1);
    cnt_d  = cmdDone ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Watchdog keeps asserting the flag while saturated, so a concurrent clear loses.
  always_comb begin
    wdog_d = wdog_q;
    if (issue) wdog_d = '0;
    else if (state_q != S_IDLE && wdog_q != WDW'(TIMEOUT)) wdog_d = wdog_q + WDW'(1);
    err_d = err_q;
    if (state_q != S_IDLE && wdog_d == WDW'(TIMEOUT)) err_d = 1'b1;
    else if (err_clear) err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (cpush) cmem_q[cwr_q] <= {q_keep, q_function_id, q_inputs_0, q_inputs_1};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cwr_q   <= '0;
      crd_q   <= '0;
      ccnt_q  <= '0;
      rwr_q   <= '0;
      rrd_q   <= '0;
      rcnt_q  <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
      keep_q  <= 1'b0;
      fid_q   <= '0;
      in0_q   <= '0;
      in1_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < RDEPTH; i++) rmem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cwr_q   <= cwr_d;
      crd_q   <= crd_d;
      ccnt_q  <= ccnt_d;
      rwr_q   <= rwr_d;
      rrd_q   <= rrd_d;
      rcnt_q  <= rcnt_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      if (issue) begin
        keep_q <= head[74];
        fid_q  <= head[73:64];
        in0_q  <= head[63:32];
        in1_q  <= head[31:0];
      end
      if (rpush) rmem_q[rwr_q] <= rsp_payload_outputs_0;
    end
  end

endmodule

// File: tb/tb_cfu_cmd_issuer.sv
// Directed bench for cfu_cmd_issuer: a cycle-by-cycle vector table for a kept read,
// then hand-written sequences for stalls, backpressure, watchdog, reset and wrap.
module tb_cfu_cmd_issuer;

  logic        clk = 1'b0;
  logic        reset;
  logic        q_valid, q_ready, q_keep;
  logic [9:0]  q_function_id;
  logic [31:0] q_inputs_0, q_inputs_1;
  logic        r_valid, r_ready;
  logic [31:0] r_data;
  logic        cmd_valid, cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0, cmd_payload_inputs_1;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  logic        busy, timeout_err, err_clear;
  logic [3:0]  issued_count;

  int nCompared = 0;
  int nFailed   = 0;

  cfu_cmd_issuer #(.QDEPTH(4), .RDEPTH(4), .TIMEOUT(16), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .q_valid(q_valid), .q_ready(q_ready), .q_function_id(q_function_id),
    .q_inputs_0(q_inputs_0), .q_inputs_1(q_inputs_1), .q_keep(q_keep),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0(cmd_payload_inputs_0), .cmd_payload_inputs_1(cmd_payload_inputs_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_payload_outputs_0),
    .busy(busy), .timeout_err(timeout_err), .err_clear(err_clear), .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        qValid;
    logic [9:0]  fid;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        keep;
    logic        cmdReady;
    logic        rspValid;
    logic [31:0] rspData;
    logic        rReady;
    logic        expCmdValid;
    logic [9:0]  expFid;
    logic [31:0] expIn0;
    logic        expRspReady;
    logic        expRValid;
    logic [31:0] expRData;
    logic        expBusy;
    logic [3:0]  expCount;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    q_valid = v.qValid;
    q_function_id = v.fid;
    q_inputs_0 = v.in0;
    q_inputs_1 = v.in1;
    q_keep = v.keep;
    cmd_ready = v.cmdReady;
    rsp_valid = v.rspValid;
    rsp_payload_outputs_0 = v.rspData;
    r_ready = v.rReady;
  endtask

  task automatic clearInputs();
    q_valid = 0; q_function_id = '0; q_inputs_0 = '0; q_inputs_1 = '0; q_keep = 0;
    r_ready = 0; cmd_ready = 0; rsp_valid = 0; rsp_payload_outputs_0 = '0; err_clear = 0;
  endtask

  task automatic applyReset();
    clearInputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic pushCmd(input logic [9:0] fid, input logic [31:0] in0, input logic [31:0] in1, input logic keep);
    int budget = 50;
    while (!q_ready && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) checkOutput("pushTimeout", 32'd0, 32'd1);
    q_valid = 1; q_function_id = fid; q_inputs_0 = in0; q_inputs_1 = in1; q_keep = keep;
    step();
    q_valid = 0;
  endtask

  task automatic waitCmdValid();
    int budget = 40;
    while (!cmd_valid && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) checkOutput("cmdValidTimeout", 32'd0, 32'd1);
  endtask

  initial begin
    // Kept read: push, issue after two edges, accept, respond, pop, then a stray rsp_valid in idle.
    vecs[0] = '{1, 10'h020, 5, 2, 1, 0, 0, 0,            0, 0, 10'h000, 0, 0, 0, 0,            1, 0};
    vecs[1] = '{0, 0,       0, 0, 0, 0, 0, 0,            0, 1, 10'h020, 5, 0, 0, 0,            1, 0};
    vecs[2] = '{0, 0,       0, 0, 0, 1, 0, 0,            0, 0, 10'h020, 5, 1, 0, 0,            1, 1};
    vecs[3] = '{0, 0,       0, 0, 0, 0, 0, 0,            0, 0, 10'h020, 5, 1, 0, 0,            1, 1};
    vecs[4] = '{0, 0,       0, 0, 0, 0, 0, 0,            0, 0, 10'h020, 5, 1, 0, 0,            1, 1};
    vecs[5] = '{0, 0,       0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 10'h020, 5, 0, 1, 32'hDEADBEEF, 0, 1};
    vecs[6] = '{0, 0,       0, 0, 0, 0, 0, 0,            0, 0, 10'h020, 5, 0, 1, 32'hDEADBEEF, 0, 1};
    vecs[7] = '{0, 0,       0, 0, 0, 0, 0, 0,            1, 0, 10'h020, 5, 0, 0, 0,            0, 1};
    vecs[8] = '{0, 0,       0, 0, 0, 0, 1, 32'h12345678, 0, 0, 10'h020, 5, 0, 0, 0,            0, 1};

    applyReset();
    checkOutput("rstCmdValid", 32'(cmd_valid), 0);
    checkOutput("rstRspReady", 32'(rsp_ready), 0);
    checkOutput("rstQReady", 32'(q_ready), 1);
    checkOutput("rstRValid", 32'(r_valid), 0);
    checkOutput("rstRData", r_data, 0);
    checkOutput("rstBusy", 32'(busy), 0);
    checkOutput("rstErr", 32'(timeout_err), 0);
    checkOutput("rstCount", 32'(issued_count), 0);
    checkOutput("rstFid", 32'(cmd_payload_function_id), 0);
    checkOutput("rstIn0", cmd_payload_inputs_0, 0);
    checkOutput("rstIn1", cmd_payload_inputs_1, 0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("v%0d.cmdValid", i), 32'(cmd_valid), 32'(vecs[i].expCmdValid));
      checkOutput($sformatf("v%0d.fid", i), 32'(cmd_payload_function_id), 32'(vecs[i].expFid));
      checkOutput($sformatf("v%0d.in0", i), cmd_payload_inputs_0, vecs[i].expIn0);
      checkOutput($sformatf("v%0d.rspReady", i), 32'(rsp_ready), 32'(vecs[i].expRspReady));
      checkOutput($sformatf("v%0d.rValid", i), 32'(r_valid), 32'(vecs[i].expRValid));
      if (vecs[i].expRValid) checkOutput($sformatf("v%0d.rData", i), r_data, vecs[i].expRData);
      checkOutput($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].expBusy));
      checkOutput($sformatf("v%0d.qReady", i), 32'(q_ready), 1);
      checkOutput($sformatf("v%0d.count", i), 32'(issued_count), 32'(vecs[i].expCount));
    end
    clearInputs();

    // Discarded load-A acks with a two-cycle cmd_ready stall each.
    applyReset();
    for (int i = 0; i < 4; i++) pushCmd(10'h008, 32'(i + 1), 32'h100 + 32'(i), 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) waitCmdValid();
      else begin
        step();
        checkOutput($sformatf("ack%0d.b2b", i), 32'(cmd_valid), 1);
      end
      for (int s = 0; s < 2; s++) begin
        checkOutput($sformatf("ack%0d.stallValid", i), 32'(cmd_valid), 1);
        checkOutput($sformatf("ack%0d.fid", i), 32'(cmd_payload_function_id), 32'h008);
        checkOutput($sformatf("ack%0d.in0", i), cmd_payload_inputs_0, 32'(i + 1));
        checkOutput($sformatf("ack%0d.in1", i), cmd_payload_inputs_1, 32'h100 + 32'(i));
        step();
      end
      cmd_ready = 1;
      step();
      cmd_ready = 0;
      checkOutput($sformatf("ack%0d.oneCycle", i), 32'(cmd_valid), 0);
      checkOutput($sformatf("ack%0d.rspReady", i), 32'(rsp_ready), 1);
      rsp_valid = 1; rsp_payload_outputs_0 = 32'h11110000 + 32'(i);
      step();
      rsp_valid = 0;
      checkOutput($sformatf("ack%0d.rValid", i), 32'(r_valid), 0);
      checkOutput($sformatf("ack%0d.busy", i), 32'(busy), 32'(i != 3));
    end
    checkOutput("ackCount", 32'(issued_count), 4);

    // Response backpressure: host never pops, only RDEPTH kept commands may issue.
    applyReset();
    cmd_ready = 1; rsp_valid = 1; rsp_payload_outputs_0 = 32'hCAFE0000;
    for (int i = 0; i < 6; i++) pushCmd(10'h040, 32'(i), 0, 1'b1);
    repeat (40) step();
    checkOutput("bpCount", 32'(issued_count), 4);
    checkOutput("bpCmdValid", 32'(cmd_valid), 0);
    checkOutput("bpRspReady", 32'(rsp_ready), 0);
    checkOutput("bpQReady", 32'(q_ready), 1);
    checkOutput("bpBusy", 32'(busy), 1);
    checkOutput("bpRValid", 32'(r_valid), 1);
    checkOutput("bpRData", r_data, 32'hCAFE0000);
    r_ready = 1;
    step();
    r_ready = 0;
    repeat (20) step();
    checkOutput("bpCountAfterPop", 32'(issued_count), 5);
    checkOutput("bpBusyAfterPop", 32'(busy), 1);
    clearInputs();

    // Watchdog: no response, flag on the 16th edge after issue, set beats clear.
    applyReset();
    cmd_ready = 1;
    pushCmd(10'h001, 0, 0, 1'b0);
    waitCmdValid();
    repeat (15) step();
    checkOutput("wdEarly", 32'(timeout_err), 0);
    step();
    checkOutput("wdSet", 32'(timeout_err), 1);
    checkOutput("wdStillWait", 32'(rsp_ready), 1);
    err_clear = 1;
    step();
    err_clear = 0;
    checkOutput("wdSetWins", 32'(timeout_err), 1);
    rsp_valid = 1;
    step();
    rsp_valid = 0;
    checkOutput("wdDoneBusy", 32'(busy), 0);
    checkOutput("wdDoneRspReady", 32'(rsp_ready), 0);
    checkOutput("wdFlagHeld", 32'(timeout_err), 1);
    err_clear = 1;
    step();
    err_clear = 0;
    checkOutput("wdCleared", 32'(timeout_err), 0);

    // Asynchronous reset while waiting with two commands queued.
    applyReset();
    cmd_ready = 1;
    for (int i = 0; i < 3; i++) pushCmd(10'h010, 32'h50 + 32'(i), 32'h60 + 32'(i), 1'b0);
    step();
    checkOutput("rmwInWait", 32'(rsp_ready), 1);
    checkOutput("rmwCountBefore", 32'(issued_count), 1);
    #2 reset = 1;
    #1;
    checkOutput("rmwCmdValid", 32'(cmd_valid), 0);
    checkOutput("rmwRspReady", 32'(rsp_ready), 0);
    checkOutput("rmwBusy", 32'(busy), 0);
    checkOutput("rmwCount", 32'(issued_count), 0);
    checkOutput("rmwFid", 32'(cmd_payload_function_id), 0);
    checkOutput("rmwIn0", cmd_payload_inputs_0, 0);
    checkOutput("rmwQReady", 32'(q_ready), 1);
    @(posedge clk);
    #1 reset = 0;
    begin
      logic sawCmd = 0;
      repeat (10) begin
        step();
        if (cmd_valid) sawCmd = 1;
      end
      checkOutput("rmwNoIssue", 32'(sawCmd), 0);
    end
    checkOutput("rmwBusyAfter", 32'(busy), 0);
    clearInputs();

    // Counter wrap: 17 accepted commands on a 4-bit counter.
    applyReset();
    cmd_ready = 1; rsp_valid = 1; rsp_payload_outputs_0 = 32'h77;
    for (int i = 0; i < 17; i++) pushCmd(10'h002, 32'(i), 0, 1'b0);
    begin
      int budget = 100;
      while (busy && budget > 0) begin
        step();
        budget--;
      end
      if (budget == 0) checkOutput("wrapTimeout", 32'd0, 32'd1);
    end
    checkOutput("wrapCount", 32'(issued_count), 1);
    checkOutput("wrapRValid", 32'(r_valid), 0);
    clearInputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
